// File: rtl/imem_loader.sv
// Instruction-memory loader: 4-byte header + little-endian words from a byte stream into imem writes.
// Optional trailing XOR checksum byte enabled by `IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int unsigned CNT_W = 16;
  localparam int unsigned SUM_W = CNT_W + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_DATA,
`ifdef IMEM_LOADER_CHECKSUM_EN
    S_CKS,
`endif
    S_DONE,
    S_ERR
  } state_e;

  // State entered once the last data word (or an empty header) has been taken.
  localparam state_e S_FIN =
`ifdef IMEM_LOADER_CHECKSUM_EN
    S_CKS;
`else
    S_DONE;
`endif

  state_e              state_q, state_d;
  logic [1:0]          cnt_q, cnt_d;
  logic [23:0]         hdr_q, hdr_d;
  logic [23:0]         wbuf_q, wbuf_d;
  logic [ADDR_W-1:0]   waddr_q, waddr_d;
  logic [CNT_W-1:0]    left_q, left_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [31:0]         mem_wdata_q, mem_wdata_d;
  logic                in_ready_q, in_ready_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]          csum_q, csum_d;
`endif

  logic                xfer;
  logic [CNT_W-1:0]    nwords;
  logic [SUM_W-1:0]    end_addr;

  assign xfer = in_valid & in_ready_q;

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hdr_d       = hdr_q;
    wbuf_d      = wbuf_q;
    waddr_d     = waddr_q;
    left_d      = left_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_d      = csum_q;
`endif
    nwords      = {in_data, hdr_q[23:16]};
    end_addr    = SUM_W'(hdr_q[15:0]) + SUM_W'(nwords);

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d = S_HDR;
          cnt_d   = 2'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d  = 8'd0;
`endif
        end
      end
      S_HDR: begin
        if (xfer) begin
          cnt_d = cnt_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d = csum_q ^ in_data;
`endif
          case (cnt_q)
            2'd0:    hdr_d[7:0]   = in_data;
            2'd1:    hdr_d[15:8]  = in_data;
            2'd2:    hdr_d[23:16] = in_data;
            default: begin
              waddr_d = ADDR_W'(hdr_q[15:0]);
              left_d  = nwords;
              if (end_addr > SUM_W'(DEPTH)) begin
                state_d = S_ERR;
              end else if (nwords == '0) begin
                state_d = S_FIN;
              end else begin
                state_d = S_DATA;
              end
            end
          endcase
        end
      end
      S_DATA: begin
        if (xfer) begin
          cnt_d = cnt_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d = csum_q ^ in_data;
`endif
          case (cnt_q)
            2'd0:    wbuf_d[7:0]   = in_data;
            2'd1:    wbuf_d[15:8]  = in_data;
            2'd2:    wbuf_d[23:16] = in_data;
            default: begin
              mem_we_d    = 1'b1;
              mem_addr_d  = waddr_q;
              mem_wdata_d = {in_data, wbuf_q};
              waddr_d     = waddr_q + ADDR_W'(1);
              left_d      = left_q - CNT_W'(1);
              if (left_q == CNT_W'(1)) state_d = S_FIN;
            end
          endcase
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CKS: begin
        if (xfer) state_d = (in_data == csum_q) ? S_DONE : S_ERR;
      end
`endif
      default: state_d = S_IDLE;
    endcase

    busy_d     = (state_d == S_HDR) || (state_d == S_DATA)
`ifdef IMEM_LOADER_CHECKSUM_EN
                 || (state_d == S_CKS)
`endif
                 ;
    in_ready_d = busy_d;
    done_d     = (state_d == S_DONE);
    err_d      = (state_d == S_ERR);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= 2'd0;
      hdr_q       <= '0;
      wbuf_q      <= '0;
      waddr_q     <= '0;
      left_q      <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hdr_q       <= hdr_d;
      wbuf_q      <= wbuf_d;
      waddr_q     <= waddr_d;
      left_q      <= left_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: doc/imem_loader.md
# imem_loader

Program loader that writes the instruction memory from a byte stream, the write-side counterpart of the fetch stage's read-only access. A host pushes a 4-byte header and little-endian instruction words over a valid/ready byte interface. The block assembles 32-bit words and issues one-cycle write strobes to the instruction memory's write port. The sequential core is held off (via `busy`) while loading.

## Interface
Parameters:
- `DEPTH`, 1024: instruction memory depth in 32-bit words.
- `ADDR_W`, 10: word-address width, equal to log2(`DEPTH`).

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse that begins a load; honoured only in IDLE, DONE or ERR.
- `in_valid`  in  1  host byte valid.
- `in_data`  in  8  host byte.
- `in_ready`  out  1  block accepts a byte this cycle; a transfer occurs when `in_valid` and `in_ready` are both 1.
- `mem_we`  out  1  one-cycle write strobe to instruction memory.
- `mem_addr`  out  `ADDR_W`  word address, i.e. the word index equivalent to PC[11:2].
- `mem_wdata`  out  32  instruction word.
- `busy`  out  1  load in progress (HDR, DATA or CKS state).
- `done`  out  1  last load completed without error; sticky until the next accepted `start`.
- `err`  out  1  last load failed; sticky until the next accepted `start`.

## Operation
- States: IDLE, HDR, DATA, CKS (only when the macro is defined), DONE, ERR.
- IDLE/DONE/ERR → HDR on `start`. This clears `done`, `err`, the byte counter and the checksum accumulator.
- `start` in HDR/DATA/CKS is ignored.
- HDR accepts 4 bytes:
  - bytes 0–1: start word address, little-endian, 16 bits.
  - bytes 2–3: word count N, little-endian, 16 bits.
- After header byte 3:
  - If start + N > `DEPTH`, compare in 17-bit arithmetic with no wrap. Go to ERR; no write is ever issued.
  - Else if N = 0: go to CKS if the macro is defined, otherwise DONE.
  - Else go to DATA.
- DATA assembles each word from 4 bytes, little-endian: first byte → [7:0], fourth byte → [31:24].
  - On the 4th byte, the word and its address are registered. `mem_we` pulses on the next cycle.
  - The address then increments. It never wraps, because the bounds check was already done.
- After word N's 4th byte: go to CKS if the macro is defined, otherwise DONE.
- `in_ready` = 1 in HDR, DATA and CKS; 0 in IDLE, DONE and ERR.
- `mem_addr`/`mem_wdata` hold their last values when `mem_we` = 0.

## Timing
- Reset values: state IDLE; `in_ready`, `mem_we`, `busy`, `done`, `err` all 0; `mem_addr` 0; `mem_wdata` 0.
- Reset mid-load aborts immediately. Words already written stay in memory; no further strobes are issued.
- Byte throughput is one per cycle with no bubbles; `in_ready` stays high through word boundaries.
- Write latency: `mem_we` is high exactly one cycle after the cycle that accepts a word's 4th byte.
- A load of N words issues exactly N strobes at consecutive addresses.
- `done`/`err` rise in the cycle after the transition condition. `busy` falls in that same cycle.
- Without the macro, `done` rises in the same cycle as the final `mem_we` pulse.
- Back-to-back loads: `start` in the first DONE cycle is honoured. `done` clears on the following edge.

## Configuration
- Macro: `IMEM_LOADER_CHECKSUM_EN`.
- Defined:
  - After the data (or after the header when N = 0), state CKS accepts one byte.
  - That byte must equal the XOR of all preceding header and data bytes of this load.
  - Match → DONE. Mismatch → ERR; words already written remain.
- Undefined: the CKS state and the accumulator are absent. The stream ends after the last data byte.

## Test plan
- Header 00 00 02 00, words 0x00500093 and 0x00A00113 streamed with `in_valid` held high → `mem_we` at addr 0 then addr 1 with those words, in consecutive strobe cycles; `done` = 1; `err` = 0.
- Header FF 03 02 00 (start 1023, N = 2) → ERR after byte 3; no `mem_we`; `in_ready` = 0.
- Header 10 00 00 00 (N = 0) → DONE with no writes. With the macro, the checksum byte must be 0x10.
- Random `in_valid` gaps on a 3-word load at address 5 → writes to 5, 6, 7 with correct data, one strobe each.
- `rst_n` pulled low after 6 data bytes → all outputs at reset values; a later `start` plus a full load succeeds.
- With the macro: correct XOR → `done` = 1; XOR with bit 0 flipped → `err` = 1 after all words are written.
